// File: rtl/opcode_extract.sv
// Instruction-stream opcode extractor: strips legacy prefixes and the 0x0F escape, then presents one opcode record.
// Optional segment-override prefix decode is enabled by defining OPX_SEG_PREFIX_EN.
module opcode_extract (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       op_valid,
  input  logic       op_ready,
  output logic [7:0] opcode,
  output logic       two_byte,
  output logic       pfx_opsize,
  output logic       pfx_lock,
  output logic       pfx_rep,
  output logic       pfx_repne,
  output logic       seg_valid,
  output logic [2:0] seg_ovr,
  output logic       pfx_err
);

  typedef enum logic [1:0] {SCAN, ESC, HOLD} state_t;

  typedef struct packed {
    logic [7:0] opcode;
    logic       two_byte;
    logic       opsize;
    logic       lock;
    logic       rep;
    logic       repne;
    logic       seg_valid;
    logic [2:0] seg_ovr;
    logic       pfx_err;
    logic [2:0] count;
  } rec_t;

  localparam logic [2:0] PFX_LIMIT = 3'd4;

  state_t     state, state_nxt;
  rec_t       rec, rec_nxt;
  logic       take;
  logic       is_seg;
  logic [2:0] seg_code;
  logic       is_prefix;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    is_seg   = 1'b0;
    seg_code = 3'd0;
`ifdef OPX_SEG_PREFIX_EN
    case (byte_in)
      8'h26: begin is_seg = 1'b1; seg_code = 3'd0; end
      8'h2E: begin is_seg = 1'b1; seg_code = 3'd1; end
      8'h36: begin is_seg = 1'b1; seg_code = 3'd2; end
      8'h3E: begin is_seg = 1'b1; seg_code = 3'd3; end
      8'h64: begin is_seg = 1'b1; seg_code = 3'd4; end
      8'h65: begin is_seg = 1'b1; seg_code = 3'd5; end
      default: ;
    endcase
`endif
    is_prefix = is_seg || (byte_in == 8'h66) || (byte_in == 8'hF0) ||
                (byte_in == 8'hF2) || (byte_in == 8'hF3);
  end

  assign byte_ready = (state != HOLD);
  assign take       = byte_valid && byte_ready;

  always_comb begin
    state_nxt = state;
    rec_nxt   = rec;
    if (flush) begin
      state_nxt = SCAN;
      rec_nxt   = '0;
    end else begin
      case (state)
        SCAN: if (take) begin
          if (byte_in == 8'h0F) begin
            rec_nxt.two_byte = 1'b1;
            state_nxt        = ESC;
          end else if (is_prefix && rec.count != PFX_LIMIT) begin
            rec_nxt.count = rec.count + 3'd1;
            if (byte_in == 8'h66) rec_nxt.opsize = 1'b1;
            if (byte_in == 8'hF0) rec_nxt.lock   = 1'b1;
            if (byte_in == 8'hF3) begin rec_nxt.rep = 1'b1; rec_nxt.repne = 1'b0; end
            if (byte_in == 8'hF2) begin rec_nxt.repne = 1'b1; rec_nxt.rep = 1'b0; end
            if (is_seg) begin rec_nxt.seg_valid = 1'b1; rec_nxt.seg_ovr = seg_code; end
          end else begin
            // A prefix arriving once the limit is reached is latched as the opcode and flagged.
            rec_nxt.opcode  = byte_in;
            rec_nxt.pfx_err = is_prefix;
            state_nxt       = HOLD;
          end
        end
        ESC: if (take) begin
          rec_nxt.opcode = byte_in;
          state_nxt      = HOLD;
        end
        HOLD: if (op_ready) begin
          rec_nxt   = '0;
          state_nxt = SCAN;
        end
        default: begin
          rec_nxt   = '0;
          state_nxt = SCAN;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SCAN;
      rec   <= '0;
    end else begin
      state <= state_nxt;
      rec   <= rec_nxt;
    end
  end

  assign op_valid   = (state == HOLD);
  assign opcode     = rec.opcode;
  assign two_byte   = rec.two_byte;
  assign pfx_opsize = rec.opsize;
  assign pfx_lock   = rec.lock;
  assign pfx_rep    = rec.rep;
  assign pfx_repne  = rec.repne;
  assign pfx_err    = rec.pfx_err;
`ifdef OPX_SEG_PREFIX_EN
  assign seg_valid  = rec.seg_valid;
  assign seg_ovr    = rec.seg_ovr;
`else
  assign seg_valid  = 1'b0;
  assign seg_ovr    = 3'd0;
`endif

endmodule

// File: tb/tb_opcode_extract.sv
// Self-checking bench for opcode_extract: directed scenarios plus randomized instruction streams
// compared against a prefix-list reference model.
module tb_opcode_extract;

  logic       clk = 1'b0;
  logic       rst, flush, byte_valid, op_ready;
  logic [7:0] byte_in;
  logic       byte_ready, op_valid, two_byte, pfx_opsize, pfx_lock, pfx_rep, pfx_repne;
  logic       seg_valid, pfx_err;
  logic [2:0] seg_ovr;
  logic [7:0] opcode;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] opcode;
    logic       two_byte;
    logic       opsize;
    logic       lock;
    logic       rep;
    logic       repne;
    logic       seg_valid;
    logic [2:0] seg_ovr;
    logic       pfx_err;
  } rec_t;

  rec_t got, exp_rec;
  assign got = {opcode, two_byte, pfx_opsize, pfx_lock, pfx_rep, pfx_repne, seg_valid, seg_ovr, pfx_err};

  opcode_extract dut (
    .clk(clk), .rst(rst), .flush(flush), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
    .two_byte(two_byte), .pfx_opsize(pfx_opsize), .pfx_lock(pfx_lock), .pfx_rep(pfx_rep),
    .pfx_repne(pfx_repne), .seg_valid(seg_valid), .seg_ovr(seg_ovr), .pfx_err(pfx_err)
  );

  always #5 clk = ~clk;

  function automatic bit seg_byte(input logic [7:0] b, output logic [2:0] code);
    code = 3'd0;
`ifdef OPX_SEG_PREFIX_EN
    case (b)
      8'h26: begin code = 3'd0; return 1'b1; end
      8'h2E: begin code = 3'd1; return 1'b1; end
      8'h36: begin code = 3'd2; return 1'b1; end
      8'h3E: begin code = 3'd3; return 1'b1; end
      8'h64: begin code = 3'd4; return 1'b1; end
      8'h65: begin code = 3'd5; return 1'b1; end
      default: return 1'b0;
    endcase
`else
    return (b == 8'hFF) && (b != 8'hFF);
`endif
  endfunction

  // Reference: collect the prefix list of one instruction, then derive the flags from it.
  function automatic void model(input logic [7:0] q[$], output rec_t e, output int used);
    logic [7:0] pfx[$];
    logic [2:0] sc;
    bit esc, done;
    e = '0; used = 0; esc = 1'b0; done = 1'b0;
    foreach (q[i]) begin
      if (!done) begin
        used++;
        if (esc) begin
          e.opcode = q[i]; done = 1'b1;
        end else if (q[i] == 8'h0F) begin
          esc = 1'b1; e.two_byte = 1'b1;
        end else if (q[i] inside {8'h66, 8'hF0, 8'hF2, 8'hF3} || seg_byte(q[i], sc)) begin
          if (pfx.size() == 4) begin
            e.opcode = q[i]; e.pfx_err = 1'b1; done = 1'b1;
          end else pfx.push_back(q[i]);
        end else begin
          e.opcode = q[i]; done = 1'b1;
        end
      end
    end
    foreach (pfx[j]) begin
      if (pfx[j] == 8'h66) e.opsize = 1'b1;
      if (pfx[j] == 8'hF0) e.lock = 1'b1;
      if (pfx[j] == 8'hF3) begin e.rep = 1'b1; e.repne = 1'b0; end
      if (pfx[j] == 8'hF2) begin e.repne = 1'b1; e.rep = 1'b0; end
      if (seg_byte(pfx[j], sc)) begin e.seg_valid = 1'b1; e.seg_ovr = sc; end
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Presents bytes until a record appears; checks consumption, latency and record contents.
  task automatic feed(input logic [7:0] q[$], input bit gaps, output int cycles);
    rec_t e;
    int used, idx;
    bit v, rdy, last_xfer;
    model(q, e, used);
    exp_rec = e; idx = 0; cycles = 0; last_xfer = 1'b0;
    while (op_valid !== 1'b1 && cycles < 100) begin
      v = (idx < q.size()) && (!gaps || $urandom_range(0, 3) != 0);
      byte_valid = v;
      byte_in    = v ? q[idx] : 8'($urandom);
      rdy        = byte_ready;
      tick();
      cycles++;
      last_xfer = v && rdy;
      if (last_xfer) idx++;
    end
    byte_valid = 1'b0;
    checks++;
    if (op_valid !== 1'b1) begin errors++; $display("FAIL feed_timeout op_valid=%b required 1", op_valid); end
    checks++;
    if (last_xfer !== 1'b1) begin errors++; $display("FAIL feed_latency record appeared without transfer on previous edge"); end
    checks++;
    if (idx != used) begin errors++; $display("FAIL feed_consumed got %0d required %0d", idx, used); end
    checks++;
    if (got !== e) begin errors++; $display("FAIL feed_record got %h required %h", got, e); end
  endtask

  // Stalls the record for hold cycles (with noise on byte_in), then performs the handshake.
  task automatic retire(input int hold);
    for (int k = 0; k < hold; k++) begin
      op_ready   = 1'b0;
      byte_valid = 1'($urandom);
      byte_in    = 8'($urandom);
      tick();
      checks++;
      if (op_valid !== 1'b1 || byte_ready !== 1'b0) begin
        errors++; $display("FAIL hold_handshake op_valid=%b byte_ready=%b required 1/0", op_valid, byte_ready);
      end
      checks++;
      if (got !== exp_rec) begin errors++; $display("FAIL hold_stable got %h required %h", got, exp_rec); end
    end
    byte_valid = 1'b0;
    op_ready   = 1'b1;
    tick();
    op_ready   = 1'b0;
    checks++;
    if (op_valid !== 1'b0 || byte_ready !== 1'b1) begin
      errors++; $display("FAIL after_handshake op_valid=%b byte_ready=%b required 0/1", op_valid, byte_ready);
    end
    checks++;
    if (got[9:0] !== 10'd0) begin errors++; $display("FAIL cleared_flags got %h required 000", got[9:0]); end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b1; byte_valid = 1'b1; byte_in = 8'h0F; op_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0; flush = 1'b0; byte_valid = 1'b0;
    checks++;
    if (op_valid !== 1'b0 || got !== '0) begin errors++; $display("FAIL reset_state op_valid=%b rec=%h required 0/0", op_valid, got); end
    checks++;
    if (byte_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", byte_ready); end
    byte_in = 8'h83;
    repeat (2) tick();
    checks++;
    if (op_valid !== 1'b0 || got !== '0) begin errors++; $display("FAIL idle_no_change op_valid=%b rec=%h required 0/0", op_valid, got); end
  endtask

  task automatic test_single_opcode();
    logic [7:0] q[$];
    int cyc;
    q = '{8'h83};
    feed(q, 1'b0, cyc);
    checks++;
    if (opcode !== 8'h83 || got[9:0] !== 10'd0) begin errors++; $display("FAIL single_opcode got %h required 83 no flags", got); end
    retire(0);
  endtask

  task automatic test_escape();
    logic [7:0] q[$];
    int cyc;
    q = '{8'h66, 8'hF3, 8'h0F, 8'hB0};
    feed(q, 1'b0, cyc);
    checks++;
    if (cyc != 4) begin errors++; $display("FAIL escape_latency got %0d required 4", cyc); end
    checks++;
    if (opcode !== 8'hB0 || two_byte !== 1'b1 || pfx_opsize !== 1'b1 || pfx_rep !== 1'b1) begin
      errors++; $display("FAIL escape_record got %h required B0 two_byte opsize rep", got);
    end
    retire(1);
  endtask

  task automatic test_rep_seg();
    logic [7:0] q[$];
    int cyc;
    q = '{8'hF3, 8'hF2, 8'h26, 8'hFF};
    feed(q, 1'b0, cyc);
    checks++;
`ifdef OPX_SEG_PREFIX_EN
    if (opcode !== 8'hFF || pfx_repne !== 1'b1 || pfx_rep !== 1'b0 || seg_valid !== 1'b1 || seg_ovr !== 3'd0) begin
      errors++; $display("FAIL rep_seg got %h required FF repne seg ES", got);
    end
`else
    if (opcode !== 8'h26 || pfx_repne !== 1'b1 || pfx_rep !== 1'b0 || seg_valid !== 1'b0) begin
      errors++; $display("FAIL rep_seg got %h required 26 repne no seg", got);
    end
`endif
    retire(2);
  endtask

  task automatic test_prefix_limit();
    logic [7:0] q[$];
    int cyc;
    q = '{8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h90};
    feed(q, 1'b0, cyc);
    checks++;
    if (pfx_err !== 1'b1 || opcode !== 8'h66 || cyc != 5) begin
      errors++; $display("FAIL prefix_limit pfx_err=%b opcode=%h cycles=%0d required 1/66/5", pfx_err, opcode, cyc);
    end
    retire(3);
  endtask

  task automatic test_flush_reset();
    logic [7:0] q[$];
    int cyc;
    byte_valid = 1'b1; byte_in = 8'h66; tick();
    byte_in = 8'h0F; tick();
    flush = 1'b1; byte_in = 8'hC1; tick();
    flush = 1'b0; byte_valid = 1'b0;
    checks++;
    if (op_valid !== 1'b0 || byte_ready !== 1'b1 || got[9:0] !== 10'd0) begin
      errors++; $display("FAIL flush_state op_valid=%b byte_ready=%b rec=%h required 0/1/clear", op_valid, byte_ready, got);
    end
    q = '{8'h90};
    feed(q, 1'b0, cyc);
    retire(0);
    q = '{8'hF0, 8'h83};
    feed(q, 1'b1, cyc);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (op_valid !== 1'b0 || got !== '0) begin errors++; $display("FAIL reset_in_hold op_valid=%b rec=%h required 0/0", op_valid, got); end
  endtask

  task automatic test_random_back_to_back();
    logic [7:0] pool[11] = '{8'h66, 8'hF0, 8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65, 8'h0F};
    logic [7:0] q[$];
    int cyc, n;
    for (int t = 0; t < 60; t++) begin
      q = {};
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) q.push_back(pool[$urandom_range(0, 10)]);
      q.push_back(8'($urandom));
      q.push_back(8'h90);
      feed(q, 1'b1, cyc);
      retire($urandom_range(0, 3));
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; op_ready = 1'b0;
    test_reset();
    test_single_opcode();
    test_escape();
    test_rep_seg();
    test_prefix_limit();
    test_flush_reset();
    test_random_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opcode_extract.md
OPCODE_EXTRACT -- requirements
Module: opcode_extract

Interface
REQ-001 clk  input  1  sole clock; all state updates on the rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 flush  input  1  synchronous pipeline flush; discards all in-flight state.
REQ-004 byte_in  input  8  next instruction byte from the fetch stream.
REQ-005 byte_valid  input  1  byte_in valid this cycle.
REQ-006 byte_ready  output  1  block accepts byte_in this cycle; a transfer occurs when byte_valid and byte_ready are both high.
REQ-007 op_valid  output  1  the opcode record outputs are valid.
REQ-008 op_ready  input  1  the downstream opcode hash/decode stage accepts the record.
REQ-009 opcode  output  8  extracted opcode byte; feeds the hash stage byte_in.
REQ-010 two_byte  output  1  opcode was preceded by the 0x0F escape.
REQ-011 pfx_opsize, pfx_lock, pfx_rep, pfx_repne  output  1 each  prefix flags for 0x66, 0xF0, 0xF3, 0xF2.
REQ-012 seg_valid, seg_ovr  output  1, 3  segment override present; ES=0, CS=1, SS=2, DS=3, FS=4, GS=5.
REQ-013 pfx_err  output  1  prefix-limit violation.

Function
REQ-014 States: SCAN (accept prefixes or opcode), ESC (0x0F was seen; the next byte is the opcode), HOLD (record presented).
REQ-015 byte_ready is 1 in SCAN and ESC, and 0 in HOLD; it is combinational from state only.
REQ-016 In SCAN, an accepted prefix byte sets its flag, increments the 3-bit prefix count, and stays in SCAN.
REQ-017 In SCAN, an accepted 0x0F moves to ESC and sets two_byte; 0x0F does not count as a prefix.
REQ-018 In SCAN, any other accepted byte is latched into opcode, and the block moves to HOLD.
REQ-019 In ESC, any accepted byte, including prefix values and 0x0F, is latched into opcode, and the block moves to HOLD.
REQ-020 Latency: op_valid rises exactly one cycle after the opcode byte transfer.
REQ-021 op_valid equals (state == HOLD); all record outputs are registered and stay stable while op_valid is 1 and op_ready is 0.
REQ-022 On op_valid and op_ready, the block clears all flags, count, two_byte and pfx_err, then enters SCAN.
REQ-023 There is no bypass: the first byte of the next instruction is accepted one cycle after the record handshake, at the earliest.
REQ-024 Repeated identical prefixes leave the flag set and still increment the count.
REQ-025 When 0xF2 and 0xF3 both occur, the later one wins: it sets its own flag and clears the other.
REQ-026 Multiple segment overrides: the last one wins in seg_ovr.
REQ-027 Prefix limit is 4. A fifth prefix byte accepted in SCAN moves the block to HOLD with pfx_err=1 and opcode equal to that byte.
REQ-028 flush has priority over byte transfer and the record handshake. On a flush cycle, no byte is consumed and no record is delivered.
REQ-029 After a flush, the next state is SCAN with all flags and the count cleared, and op_valid is 0.
REQ-030 byte_in is ignored when byte_valid is 0; there are no state changes without a transfer, flush or handshake.

Reset
REQ-031 rst forces SCAN and has priority over flush.
REQ-032 On reset, op_valid, opcode, two_byte, all pfx_* outputs, seg_valid, seg_ovr, pfx_err and the count are all 0.
REQ-033 byte_ready is 1 in the first cycle after reset deasserts.
REQ-034 rst asserted mid-instruction discards the partial prefix state and any held record without a handshake.

Configuration
REQ-035 Macro OPX_SEG_PREFIX_EN controls segment-override prefix decode.
REQ-036 With OPX_SEG_PREFIX_EN defined, bytes 0x26, 0x2E, 0x36, 0x3E, 0x64 and 0x65 are prefixes per REQ-012/016.
REQ-037 Without OPX_SEG_PREFIX_EN, those bytes are ordinary opcodes per REQ-018, and seg_valid and seg_ovr are constant 0.

Verification
REQ-038 Byte 0x83, op_ready=1: op_valid next cycle, opcode=0x83, all flags 0, byte_ready=1 one cycle after the handshake.
REQ-039 Stream 0x66,0xF3,0x0F,0xB0: opcode=0xB0, two_byte=1, pfx_opsize=1, pfx_rep=1, op_valid 4 cycles after the first byte.
REQ-040 Stream 0xF3,0xF2,0x26,0xFF with OPX_SEG_PREFIX_EN: pfx_repne=1, pfx_rep=0, seg_valid=1, seg_ovr=0, opcode=0xFF; without the macro: opcode=0x26, seg_valid=0.
REQ-041 Five bytes of 0x66: HOLD after the fifth, pfx_err=1, opcode=0x66; hold op_ready=0 for 3 cycles and check the outputs are stable and byte_ready=0.
REQ-042 Stream 0x66,0x0F, then flush together with byte_valid for 0xC1: 0xC1 is not consumed and the next record shows no flags; rst asserted while in HOLD gives op_valid=0 the next cycle.
